// File: rtl/ascensor_pkg.sv
// Shared definitions for the elevator destination sequencer:
// floor codes, reset floor, FSM state enum and counter width helper.
package ascensor_pkg;

    localparam logic [1:0] PISO_MENOS_UNO = 2'b00;
    localparam logic [1:0] PISO_UNO       = 2'b01;
    localparam logic [1:0] PISO_DOS       = 2'b10;
    localparam logic [1:0] PISO_TRES      = 2'b11;
    localparam logic [1:0] PISO_RESET     = PISO_UNO;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MOVE,
        DOOR,
        DONE
    } estado_t;

    // Bits needed to count 0 .. max(a,b)-1.
    function automatic int ancho_contador(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/contador_tiempo.sv
// Loadable cycle counter with clear and terminal-count flag.
// Ports: clk, rst_n (sync, active low), clr_i, load_i, load_val_i,
//        en_i, limite_i (terminal value), tc_o (count == limite_i).
module contador_tiempo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] limite_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limite_i);

endmodule

// File: rtl/controlador_destinos.sv
// Elevator sequencer: walks the destination queue, moves the car one
// floor per TRAVEL_CYCLES toward each entry, then opens the door for
// DOOR_CYCLES. Inputs: clk, rst_n (sync, active low), start,
// destino_in (floor code at address), hold_puerta (only with
// PUERTA_HOLD_EN defined: freezes the door timer). Outputs: address,
// piso_actual, motor_subir, motor_bajar, puerta_abierta, ocupado, fin.
module controlador_destinos
    import ascensor_pkg::*;
#(
    parameter int QUEUE_LEN     = 10,
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef PUERTA_HOLD_EN
    input  logic       hold_puerta,
`endif
    input  logic [1:0] destino_in,
    output logic [7:0] address,
    output logic [1:0] piso_actual,
    output logic       motor_subir,
    output logic       motor_bajar,
    output logic       puerta_abierta,
    output logic       ocupado,
    output logic       fin
);

    localparam int CW = ancho_contador(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [CW-1:0] LIM_MOVE  = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] LIM_DOOR  = CW'(DOOR_CYCLES - 1);
    localparam logic [7:0]    ADDR_LAST = 8'(QUEUE_LEN - 1);

    estado_t    estado_q, estado_d;
    logic [7:0] addr_q, addr_d;
    logic [1:0] piso_q, piso_d;
    logic [1:0] obj_q, obj_d;

    logic          pausa;
    logic          sube, baja;
    logic          en_move, en_door;
    logic          cnt_en, cnt_clr, cnt_tc;
    logic [CW-1:0] cnt_lim;

`ifdef PUERTA_HOLD_EN
    assign pausa = hold_puerta;
`else
    assign pausa = 1'b0;
`endif

    assign sube    = (obj_q > piso_q);
    assign baja    = (obj_q < piso_q);
    assign en_move = (estado_q == MOVE);
    assign en_door = (estado_q == DOOR);

    // One timer serves both travel and door phases; it is cleared on
    // terminal count and whenever the FSM is outside those phases.
    assign cnt_en  = en_move | (en_door & ~pausa);
    assign cnt_lim = en_move ? LIM_MOVE : LIM_DOOR;
    assign cnt_clr = (cnt_en & cnt_tc) | ~(en_move | en_door);

    contador_tiempo #(
        .W(CW)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .load_i    (1'b0),
        .load_val_i({CW{1'b0}}),
        .en_i      (cnt_en),
        .limite_i  (cnt_lim),
        .tc_o      (cnt_tc)
    );

    always_comb begin
        estado_d = estado_q;
        addr_d   = addr_q;
        piso_d   = piso_q;
        obj_d    = obj_q;
        unique case (estado_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    estado_d = FETCH;
                end
            end
            FETCH: begin
                obj_d    = destino_in;
                estado_d = (destino_in == piso_q) ? DOOR : MOVE;
            end
            MOVE: begin
                if (cnt_tc) begin
                    piso_d = sube ? piso_q + 2'd1 : piso_q - 2'd1;
                    if (piso_d == obj_q) begin
                        estado_d = DOOR;
                    end
                end
            end
            DOOR: begin
                if (cnt_tc && !pausa) begin
                    if (addr_q == ADDR_LAST) begin
                        estado_d = DONE;
                    end else begin
                        addr_d   = addr_q + 8'd1;
                        estado_d = FETCH;
                    end
                end
            end
            DONE: begin
                estado_d = IDLE;
                addr_d   = '0;
            end
            default: begin
                estado_d = IDLE;
                addr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            addr_q   <= '0;
            piso_q   <= PISO_RESET;
            obj_q    <= PISO_RESET;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            piso_q   <= piso_d;
            obj_q    <= obj_d;
        end
    end

    assign address        = addr_q;
    assign piso_actual    = piso_q;
    assign motor_subir    = en_move & sube;
    assign motor_bajar    = en_move & baja;
    assign puerta_abierta = en_door;
    assign ocupado        = (estado_q != IDLE);
    assign fin            = (estado_q == DONE);

endmodule

// File: tb/tb_controlador_destinos.sv
// Self-checking bench for controlador_destinos (TRAVEL=2, DOOR=3).
// Two instances: QUEUE_LEN=2 and QUEUE_LEN=1, each fed by a queue model.
module tb_controlador_destinos;

    logic clk;
    logic rst_n;

    logic       start, start1;
    logic [1:0] destino_in, destino1;
    logic [7:0] address, address1;
    logic [1:0] piso_actual, piso1;
    logic       motor_subir, motor_bajar, puerta_abierta, ocupado, fin;
    logic       sub1, baj1, door1, ocup1, fin1;
`ifdef PUERTA_HOLD_EN
    logic hold0, hold1;
`endif

    logic [1:0] q [2];
    logic [1:0] q1;

    assign destino_in = q[address[0]];
    assign destino1   = q1;

    controlador_destinos #(
        .QUEUE_LEN(2), .TRAVEL_CYCLES(2), .DOOR_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef PUERTA_HOLD_EN
        .hold_puerta(hold0),
`endif
        .destino_in(destino_in), .address(address),
        .piso_actual(piso_actual), .motor_subir(motor_subir),
        .motor_bajar(motor_bajar), .puerta_abierta(puerta_abierta),
        .ocupado(ocupado), .fin(fin)
    );

    controlador_destinos #(
        .QUEUE_LEN(1), .TRAVEL_CYCLES(2), .DOOR_CYCLES(3)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef PUERTA_HOLD_EN
        .hold_puerta(hold1),
`endif
        .destino_in(destino1), .address(address1),
        .piso_actual(piso1), .motor_subir(sub1),
        .motor_bajar(baj1), .puerta_abierta(door1),
        .ocupado(ocup1), .fin(fin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic [7:0] addr;
        logic [1:0] piso;
        logic       sub;
        logic       baj;
        logic       door;
        logic       ocup;
        logic       fin;
    } vec_t;

    vec_t tabla [18];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic s, input logic [7:0] a,
                                input logic [1:0] p, input logic su,
                                input logic ba, input logic d,
                                input logic o, input logic f);
        vec_t v;
        v = '{s, a, p, su, ba, d, o, f};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [13:0] outs0();
        return {address, piso_actual, motor_subir, motor_bajar,
                puerta_abierta, ocupado, fin};
    endfunction

    function automatic logic [13:0] outs1();
        return {address1, piso1, sub1, baj1, door1, ocup1, fin1};
    endfunction

    initial begin
        int fk, nb, ns, nd, mv_after, nmot;
        bit seen_door, ok;

        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        q[0]   = 2'b01;
        q[1]   = 2'b01;
        q1     = 2'b01;
`ifdef PUERTA_HOLD_EN
        hold0 = 1'b0;
        hold1 = 1'b0;
`endif

        // expected output vectors after each edge of the [11,01] run
        tabla[0]  = mk(1, 8'd0, 2'b01, 0, 0, 0, 1, 0);
        tabla[1]  = mk(0, 8'd0, 2'b01, 1, 0, 0, 1, 0);
        tabla[2]  = mk(0, 8'd0, 2'b01, 1, 0, 0, 1, 0);
        tabla[3]  = mk(0, 8'd0, 2'b10, 1, 0, 0, 1, 0);
        tabla[4]  = mk(0, 8'd0, 2'b10, 1, 0, 0, 1, 0);
        tabla[5]  = mk(0, 8'd0, 2'b11, 0, 0, 1, 1, 0);
        tabla[6]  = mk(0, 8'd0, 2'b11, 0, 0, 1, 1, 0);
        tabla[7]  = mk(0, 8'd0, 2'b11, 0, 0, 1, 1, 0);
        tabla[8]  = mk(0, 8'd1, 2'b11, 0, 0, 0, 1, 0);
        tabla[9]  = mk(0, 8'd1, 2'b11, 0, 1, 0, 1, 0);
        tabla[10] = mk(0, 8'd1, 2'b11, 0, 1, 0, 1, 0);
        tabla[11] = mk(0, 8'd1, 2'b10, 0, 1, 0, 1, 0);
        tabla[12] = mk(0, 8'd1, 2'b10, 0, 1, 0, 1, 0);
        tabla[13] = mk(0, 8'd1, 2'b01, 0, 0, 1, 1, 0);
        tabla[14] = mk(0, 8'd1, 2'b01, 0, 0, 1, 1, 0);
        tabla[15] = mk(0, 8'd1, 2'b01, 0, 0, 1, 1, 0);
        tabla[16] = mk(0, 8'd1, 2'b01, 0, 0, 0, 1, 1);
        tabla[17] = mk(0, 8'd0, 2'b01, 0, 0, 0, 0, 0);

        tick();
        tick();
        chk("reset_dut", 32'(outs0()), 32'({8'h00, 2'b01, 5'b0}));
        chk("reset_dut1", 32'(outs1()), 32'({8'h00, 2'b01, 5'b0}));
        rst_n = 1'b1;
        tick();

        // queue [11,01] cycle by cycle
        q[0] = 2'b11;
        q[1] = 2'b01;
        for (int i = 0; i < 18; i++) begin
            start = tabla[i].start;
            tick();
            start = 1'b0;
            chk($sformatf("run1_row%0d", i), 32'(outs0()),
                32'(tabla[i][13:0]));
        end

        // queue [01] at reset floor, QUEUE_LEN=1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        fk = 0;
        nmot = 0;
        for (int k = 1; k <= 20; k++) begin
            nmot += int'(sub1 | baj1);
            if (fin1) begin
                fk = k;
                break;
            end
            tick();
        end
        chk("same_floor_fin_latency", 32'(fk), 32'd5);
        chk("same_floor_no_motor", 32'(nmot), 32'd0);
        tick();

        // queue [00,00] from floor 01
        q[0] = 2'b00;
        q[1] = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        fk = 0; nb = 0; ns = 0; nd = 0; mv_after = 0;
        seen_door = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            nb += int'(motor_bajar);
            ns += int'(motor_subir);
            nd += int'(puerta_abierta);
            if (seen_door)
                mv_after += int'(motor_bajar | motor_subir);
            if (puerta_abierta)
                seen_door = 1'b1;
            if (fin) begin
                fk = k;
                break;
            end
            tick();
        end
        chk("low_bajar_cycles", 32'(nb), 32'd2);
        chk("low_subir_cycles", 32'(ns), 32'd0);
        chk("low_door_cycles", 32'(nd), 32'd6);
        chk("low_motion_between_doors", 32'(mv_after), 32'd0);
        chk("low_fin_cycle", 32'(fk), 32'd11);
        chk("low_floor", 32'(piso_actual), 32'(2'b00));
        tick();

        // start held high for the whole run from floor 00 to [01,01]
        q[0] = 2'b01;
        q[1] = 2'b01;
        start = 1'b1;
        tick();
        fk = 0;
        for (int k = 1; k <= 20; k++) begin
            if (fin) begin
                fk = k;
                break;
            end
            tick();
        end
        chk("held_start_fin_cycle", 32'(fk), 32'd11);
        start = 1'b0;
        tick();
        chk("held_start_idle", 32'({ocupado, address}), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_fetch",
            32'({ocupado, puerta_abierta, motor_subir, address}),
            32'({1'b1, 1'b0, 1'b0, 8'd0}));
        ok = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (fin) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("restart_completes", 32'(ok), 32'd1);
        tick();

        // reset in MOVE at floor 10
        q[0] = 2'b11;
        q[1] = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (motor_subir && piso_actual == 2'b10) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_move_floor2", 32'(ok), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("reset_in_move", 32'(outs0()), 32'({8'h00, 2'b01, 5'b0}));
        tick();
        chk("idle_after_reset", 32'(outs0()), 32'({8'h00, 2'b01, 5'b0}));

`ifdef PUERTA_HOLD_EN
        q1 = 2'b01;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        nd = int'(door1);
        hold1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            nd += int'(door1);
        end
        hold1 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fin1) begin
                ok = 1'b1;
                break;
            end
            nd += int'(door1);
        end
        chk("hold_door_cycles", 32'(nd), 32'd8);
        chk("hold_completes", 32'(ok), 32'd1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
